// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmitter files.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_DEF_CLK_HZ = 100_000_000;
    localparam int UART_DEF_BAUD   = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    // Bit period in system clocks, truncated toward zero.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two circular byte queue.
// The pointers carry one extra wrap bit so that full and empty can be told apart.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = UART_DATA_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter, LSB first, bytes accepted on a valid/ready handshake.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH byte queue; otherwise a single holding register.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit period
//   DATA  | data bits d[0]..d[7], one bit period each
//   STOP  | stop bit (high); next queued byte starts without a gap
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = UART_DEF_CLK_HZ,
    parameter int BAUD       = UART_DEF_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [UART_DATA_BITS-1:0] tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      tx_o,
    output logic                      busy_o
);

    localparam int DIV   = uart_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_core: CLK_HZ/BAUD must be >= 2 and FIFO_DEPTH a power of two >= 2");
    end

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      push, pop;
    logic                      q_empty, q_full, q_last;
    logic [UART_DATA_BITS-1:0] q_head;
    logic                      bit_end;

    assign push       = tx_valid_i && !q_full;
    assign tx_ready_o = !q_full;
    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign bit_end    = (cnt_q == CNT_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int QW = $clog2(FIFO_DEPTH) + 1;
    logic [QW-1:0] q_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (tx_data_i),
        .pop_i   (pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign q_last = (q_count == QW'(1));
`else
    logic                      hold_valid_q, hold_valid_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;

    // Push only happens while empty and pop only while full, so they never coincide.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (pop) hold_valid_d = 1'b0;
        if (push) begin
            hold_valid_d = 1'b1;
            hold_d       = tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign q_empty = !hold_valid_q;
    assign q_full  = hold_valid_q;
    assign q_last  = hold_valid_q;
    assign q_head  = hold_q;
`endif

    // tx_d is the line level for the next cycle, so tx stays a plain register.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!q_empty) begin
                    pop     = 1'b1;
                    shift_d = q_head;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        bit_d   = bit_q + BIT_ONE;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!q_empty) begin
                        pop     = 1'b1;
                        shift_d = q_head;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE) || push || (!q_empty && !(pop && q_last));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core at a short bit period (1 MHz / 52 kBd -> 19 clocks).
// Works with or without UART_TX_FIFO_EN; accept-cycle expectations follow the build.
module tb_uart_tx_core;

    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 52_000;
    localparam int DIV        = 19;    // 1_000_000 / 52_000 = 19.23, truncated
    localparam int FIFO_DEPTH = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic [31:0] rx_word = '0;
    logic [31:0] cr_word = '0;

    uart_tx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_o       (tx),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Holds tx_valid until the handshake; returns the cycle in which it was accepted.
    task automatic push_byte(input logic [7:0] b, output int acc_cyc);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 40 * DIV && tx_ready !== 1'b1; t++) @(negedge clk);
        check($sformatf("push_ready_%02h", b), tx_ready, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    // Called at the negedge of the first start-bit cycle; leaves at the cycle after the stop bit.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] fr;
        logic [7:0] rx;
        fr = {1'b1, b, 1'b0};
        rx = '0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < DIV; k++) begin
                if (k == 0)       check($sformatf("frm%02h_bit%0d_first", b, i), tx, fr[i]);
                if (k == DIV - 1) check($sformatf("frm%02h_bit%0d_last", b, i), tx, fr[i]);
                if (k == DIV / 2 && i >= 1 && i <= 8) rx[i-1] = tx;
                @(negedge clk);
            end
        end
        check($sformatf("rx_byte_%02h", b), rx, b);
        if (rx == 8'h0D) begin
            cr_word = rx_word;
            $display("RX word 0x%08h on CR", rx_word);
        end else begin
            rx_word = {rx_word[23:0], rx};
        end
    endtask

    logic [7:0] burst [7];
    int         acc [7];
    int         exp_acc [7];
    int         t0, a0, a1, a2, highs;

    initial begin
        burst = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h45, 8'h46};
`ifdef UART_TX_FIFO_EN
        exp_acc = '{0, 1, 2, 3, 4, 2 + 10 * DIV, 2 + 20 * DIV};
`else
        exp_acc = '{0, 2, 2 + 10 * DIV, 2 + 20 * DIV, 2 + 30 * DIV, 2 + 40 * DIV, 2 + 50 * DIV};
`endif

        // reset and idle line
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        highs = 0;
        for (int i = 0; i < 10 * DIV; i++) begin
            @(negedge clk);
            if (tx === 1'b1) highs++;
        end
        check("idle_line_high", highs, 10 * DIV);
        check("idle_busy", busy, 1'b0);

        // single byte 0x41
        push_byte(8'h41, a0);
        tx_valid = 1'b0;
        check("single_tx_n1", tx, 1'b1);
        check("single_busy_n1", busy, 1'b1);
        @(negedge clk);
        check("single_tx_n2", tx, 1'b0);
        check_frame(8'h41);
        check("single_busy_end", busy, 1'b0);
        check("single_tx_end", tx, 1'b1);

        // 0x00 and 0xFF back to back
        t0 = cyc;
        fork
            begin
                push_byte(8'h00, a0);
                push_byte(8'hFF, a1);
                tx_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                check_frame(8'h00);
                check_frame(8'hFF);
            end
        join
        check("bnd_acc0", a0 - t0, 0);
`ifdef UART_TX_FIFO_EN
        check("bnd_acc1", a1 - t0, 1);
`else
        check("bnd_acc1", a1 - t0, 2);
`endif
        check("bnd_busy_end", busy, 1'b0);

        // burst "ABCD\r" E F with tx_valid held
        rx_word = '0;
        t0 = cyc;
        fork
            begin
                for (int k = 0; k < 7; k++) begin
`ifdef UART_TX_FIFO_EN
                    if (k == 5) check("burst_full_ready", tx_ready, 1'b0);
`else
                    if (k == 1) check("hold_full_ready", tx_ready, 1'b0);
`endif
                    push_byte(burst[k], acc[k]);
                end
                tx_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 7; k++) check_frame(burst[k]);
            end
        join
        for (int k = 0; k < 7; k++) check($sformatf("burst_acc%0d", k), acc[k] - t0, exp_acc[k]);
        check("burst_cr_word", cr_word, 32'h4142_4344);
        check("burst_busy_end", busy, 1'b0);

        // reset during data bit 3 of 0x55 with bytes waiting
        t0 = cyc;
        push_byte(8'h55, a0);
        push_byte(8'h33, a1);
`ifdef UART_TX_FIFO_EN
        push_byte(8'h99, a2);
`endif
        tx_valid = 1'b0;
        while (cyc < t0 + 2 + 4 * DIV + DIV / 2) @(negedge clk);
        check("midrst_pre_tx", tx, 1'b0);
        check("midrst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", tx_ready, 1'b1);
        highs = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            @(negedge clk);
            if (tx === 1'b1) highs++;
        end
        check("midrst_line_quiet", highs, 12 * DIV);
        check("midrst_busy_quiet", busy, 1'b0);
        push_byte(8'h0D, a0);
        tx_valid = 1'b0;
        @(negedge clk);
        check_frame(8'h0D);
        check("post_rst_busy_end", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
